thread_pc_sequencer: RTL and testbench
======================================

# thread_pc_sequencer

- Multithreaded program-counter sequencer for the next-generation Octavo control path.
- Holds one PC per hardware thread and issues one (thread, PC) pair per cycle in strict round-robin order.
- Applies per-thread feedback from the datapath: sequential advance, taken jump, or I/O-not-ready replay.
- Adds run/halt control per thread, which the scalar control path lacks; the Instruction Memory read address is driven from this block's issue outputs.

## Interface
Parameters:
- PC_WIDTH, 10, width of instruction address.
- THREAD_COUNT, 8, number of hardware threads; any value ≥ 2 (non-power-of-two legal).
- THREAD_ADDR_WIDTH, 3, width of thread IDs; must be ≥ clog2(THREAD_COUNT).
- RESET_PC, 0, PC loaded into every thread at reset.
- RESET_RUN_MASK, all ones, bit t = thread t runs after reset.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- issue_valid  out  1  slot carries a live instruction; 0 = annulled slot (halted thread).
- issue_thread  out  THREAD_ADDR_WIDTH  thread owning this slot.
- issue_pc  out  PC_WIDTH  instruction address for this slot.
- fb_valid  in  1  feedback present for fb_thread.
- fb_thread  in  THREAD_ADDR_WIDTH  thread the feedback applies to.
- fb_io_ready  in  1  0 = instruction must replay (PC unchanged).
- fb_jump  in  1  taken branch/jump.
- fb_target  in  PC_WIDTH  jump destination.
- ctrl_valid  in  1  run/halt command present.
- ctrl_op  in  1  0 = HALT, 1 = START.
- ctrl_thread  in  THREAD_ADDR_WIDTH  target thread.
- ctrl_pc  in  PC_WIDTH  start PC for START.
- running  out  THREAD_COUNT  per-thread run state, registered.

## Operation
- Round-robin counter `rr` steps 0,1,…,THREAD_COUNT-1, then wraps to 0. It advances every cycle unconditionally; slots are never skipped or stalled.
- Each cycle the issue registers load from `rr`:
  - issue_thread = rr.
  - issue_pc = next-state PC of thread rr.
  - issue_valid = next-state run bit of thread rr.
- Feedback update, applied only if fb_valid and thread fb_thread is running:
  - fb_io_ready=0 → PC unchanged (replay). Takes priority over fb_jump.
  - fb_io_ready=1, fb_jump=1 → PC = fb_target.
  - fb_io_ready=1, fb_jump=0 → PC = PC+1, wrapping modulo 2^PC_WIDTH.
- Control commands:
  - START: run bit := 1 and PC := ctrl_pc, even if the thread is already running (restart).
  - HALT: run bit := 0; PC retained.
- Same thread, same cycle, both fb_valid and ctrl_valid: the control command wins and the feedback is discarded.
- Feedback for a halted thread is ignored.
- fb_thread or ctrl_thread ≥ THREAD_COUNT: command ignored, no state change.
- Halted threads still occupy their slot, with issue_valid=0 and issue_pc = retained PC.

## Timing
- Reset (reset_n=0 at an edge), including mid-operation:
  - rr=0; all PCs = RESET_PC; run bits = RESET_RUN_MASK.
  - issue_valid=0, issue_thread=0, issue_pc=0; running = RESET_RUN_MASK.
  - Feedback and control inputs in the same cycle are ignored.
- First edge with reset_n=1: issue_thread=0, issue_pc=RESET_PC, issue_valid=RESET_RUN_MASK[0].
- Issue latency: 1 cycle from `rr` to the outputs.
- Feedback or control arriving in cycle N for thread T:
  - Visible in T's PC and run state after edge N.
  - If rr==T in cycle N, the issued slot already reflects the update (same-cycle bypass, so there is no stale PC).
- `running` reflects control commands one cycle after ctrl_valid.

## Structure
- Shared package `octavo_thread_pkg`:
  - ctrl_op encodings CTRL_HALT=1'b0, CTRL_START=1'b1.
  - Thread-ID typedef sized by THREAD_ADDR_WIDTH.
- Sub-module `thread_round_robin`: parametrised wrapping counter with synchronous active-low reset, reusable by the datapath thread tracking.
- PC storage: a register array. It must not be block RAM, because the same-cycle bypass and the concurrent feedback write need combinational read-modify-write.

## Test plan
- Reset with THREAD_COUNT=8, RESET_PC=0x10, mask 0xFF → issue_thread sequence 0..7,0 with issue_pc=0x10, issue_valid=1 in every slot; running=0xFF.
- Feedback fb_thread=3, io_ready=1, jump=0, sent on each visit → thread 3 PCs 0x10, 0x11, 0x12 on successive visits. Jump to 0x3FF followed by a sequential advance → 0x3FF then wraps to 0x000.
- Thread 5 with fb_io_ready=0 and fb_jump=1, target 0x200 → thread 5 re-issues its same PC; the target is ignored.
- HALT thread 2 → its slots show issue_valid=0 with PC retained. START thread 2 at 0x080 in the same cycle as feedback for thread 2 → next slot for thread 2: valid=1, pc=0x080.
- Feedback for thread 4 in the same cycle rr==4 → that slot's issue_pc already shows the updated PC.
- THREAD_COUNT=6: rr wraps 5→0. ctrl_thread=7 → ignored, running unchanged. reset_n=0 mid-sequence → outputs return to the reset values above on the next edge.

Source files
------------

// File: rtl/octavo_thread_pkg.sv
// octavo_thread_pkg
// Shared definitions for the Octavo multithreaded control path.
//   ctrl_op_e   : run/halt command encoding carried on ctrl_op.
//   thread_id_t : thread identifier at the default thread-address width.
// No ports; imported by the sequencer and its round-robin counter.
package octavo_thread_pkg;

    typedef enum logic {
        CTRL_HALT  = 1'b0,
        CTRL_START = 1'b1
    } ctrl_op_e;

    localparam int DEFAULT_THREAD_ADDR_WIDTH = 3;

    typedef logic [DEFAULT_THREAD_ADDR_WIDTH-1:0] thread_id_t;

endpackage

// File: rtl/thread_round_robin.sv
// thread_round_robin
// Wrapping thread counter: 0,1,...,COUNT-1,0,... advancing on every rising
// clock edge. Shared by the PC sequencer and datapath thread tracking.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset, forces count to 0
//   count   : current thread slot
module thread_round_robin
    import octavo_thread_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [WIDTH-1:0] count
);

    // Explicit wrap compare so non-power-of-two thread counts work.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count == WIDTH'(COUNT - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/thread_pc_sequencer.sv
// thread_pc_sequencer
// Holds one PC and one run bit per hardware thread and issues one
// (thread, PC) pair per cycle in strict round-robin order. Datapath feedback
// advances, redirects or replays a thread's PC; control commands start or
// halt threads.
// Ports:
//   clock, reset_n                 : clock, synchronous active-low reset
//   issue_valid/thread/pc          : registered issue slot (valid=0 for halted)
//   fb_valid/thread/io_ready/jump/target : per-thread datapath feedback
//   ctrl_valid/op/thread/pc        : START (with PC) / HALT command
//   running                        : registered per-thread run state
module thread_pc_sequencer
    import octavo_thread_pkg::*;
#(
    parameter int                      PC_WIDTH          = 10,
    parameter int                      THREAD_COUNT      = 8,
    parameter int                      THREAD_ADDR_WIDTH = 3,
    parameter logic [PC_WIDTH-1:0]     RESET_PC          = '0,
    parameter logic [THREAD_COUNT-1:0] RESET_RUN_MASK    = '1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    output logic                         issue_valid,
    output logic [THREAD_ADDR_WIDTH-1:0] issue_thread,
    output logic [PC_WIDTH-1:0]          issue_pc,
    input  logic                         fb_valid,
    input  logic [THREAD_ADDR_WIDTH-1:0] fb_thread,
    input  logic                         fb_io_ready,
    input  logic                         fb_jump,
    input  logic [PC_WIDTH-1:0]          fb_target,
    input  logic                         ctrl_valid,
    input  logic                         ctrl_op,
    input  logic [THREAD_ADDR_WIDTH-1:0] ctrl_thread,
    input  logic [PC_WIDTH-1:0]          ctrl_pc,
    output logic [THREAD_COUNT-1:0]      running
);

    // PC storage is a flop array: the bypass below reads the freshly
    // computed next PC in the same cycle it is written.
    logic [PC_WIDTH-1:0]          pc_q    [THREAD_COUNT];
    logic [PC_WIDTH-1:0]          pc_next [THREAD_COUNT];
    logic [THREAD_COUNT-1:0]      run_next;
    logic [THREAD_ADDR_WIDTH-1:0] rr;

    thread_round_robin #(
        .COUNT (THREAD_COUNT),
        .WIDTH (THREAD_ADDR_WIDTH)
    ) u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .count   (rr)
    );

    // Next-state decode per thread. Thread IDs at or above THREAD_COUNT never
    // match any t, so out-of-range commands fall through as no-ops. A control
    // command to the same thread overrides (and discards) its feedback;
    // feedback for a halted thread is ignored; io_ready=0 replays.
    always_comb begin
        run_next = running;
        for (int t = 0; t < THREAD_COUNT; t++) begin
            pc_next[t] = pc_q[t];
            if (ctrl_valid && ctrl_thread == THREAD_ADDR_WIDTH'(t)) begin
                if (ctrl_op == CTRL_START) begin
                    run_next[t] = 1'b1;
                    pc_next[t]  = ctrl_pc;
                end else begin
                    run_next[t] = 1'b0;
                end
            end else if (fb_valid && fb_thread == THREAD_ADDR_WIDTH'(t)
                         && running[t] && fb_io_ready) begin
                pc_next[t] = fb_jump ? fb_target : pc_q[t] + 1'b1;
            end
        end
    end

    // State and issue registers. The issue slot samples next-state values so
    // an update for the thread being issued is already visible in its slot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int t = 0; t < THREAD_COUNT; t++) begin
                pc_q[t] <= RESET_PC;
            end
            running      <= RESET_RUN_MASK;
            issue_valid  <= 1'b0;
            issue_thread <= '0;
            issue_pc     <= '0;
        end else begin
            for (int t = 0; t < THREAD_COUNT; t++) begin
                pc_q[t] <= pc_next[t];
            end
            running      <= run_next;
            issue_valid  <= run_next[rr];
            issue_thread <= rr;
            issue_pc     <= pc_next[rr];
        end
    end

endmodule

// File: tb/tb_thread_pc_sequencer.sv
// tb_thread_pc_sequencer
// Drives an 8-thread and a 6-thread sequencer from one shared stimulus stream
// and compares both against a per-thread behavioural model every cycle,
// plus hand-computed literal checks for the directed scenarios.
module tb_thread_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       fb_valid, fb_io_ready, fb_jump;
    logic [2:0] fb_thread;
    logic [9:0] fb_target;
    logic       ctrl_valid, ctrl_op;
    logic [2:0] ctrl_thread;
    logic [9:0] ctrl_pc;

    logic       v8, v6;
    logic [2:0] th8, th6;
    logic [9:0] pc8, pc6;
    logic [7:0] run8;
    logic [5:0] run6;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = 8-thread DUT, 1 = 6-thread DUT
    int       cnt   [2] = '{8, 6};
    int       rpc   [2] = '{'h10, 'h20};
    int       rmask [2] = '{'hFF, 'h2D};
    int       mpc   [2][8];
    bit       mrun  [2][8];
    int       mslot [2];
    int       e_pc  [2];
    int       e_th  [2];
    int       e_v   [2];
    int       e_run [2];
    bit       model_live = 1'b0;
    bit       ctrl_ok, fb_ok;
    int       r;

    always #5 clock = ~clock;

    thread_pc_sequencer #(
        .PC_WIDTH(10), .THREAD_COUNT(8), .THREAD_ADDR_WIDTH(3),
        .RESET_PC(10'h010), .RESET_RUN_MASK(8'hFF)
    ) dut8 (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(v8), .issue_thread(th8), .issue_pc(pc8),
        .fb_valid(fb_valid), .fb_thread(fb_thread), .fb_io_ready(fb_io_ready),
        .fb_jump(fb_jump), .fb_target(fb_target),
        .ctrl_valid(ctrl_valid), .ctrl_op(ctrl_op), .ctrl_thread(ctrl_thread),
        .ctrl_pc(ctrl_pc), .running(run8)
    );

    thread_pc_sequencer #(
        .PC_WIDTH(10), .THREAD_COUNT(6), .THREAD_ADDR_WIDTH(3),
        .RESET_PC(10'h020), .RESET_RUN_MASK(6'b101101)
    ) dut6 (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(v6), .issue_thread(th6), .issue_pc(pc6),
        .fb_valid(fb_valid), .fb_thread(fb_thread), .fb_io_ready(fb_io_ready),
        .fb_jump(fb_jump), .fb_target(fb_target),
        .ctrl_valid(ctrl_valid), .ctrl_op(ctrl_op), .ctrl_thread(ctrl_thread),
        .ctrl_pc(ctrl_pc), .running(run6)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: each edge applies the thread's command, then the
    // slot number since reset (mod thread count) picks which thread issues.
    always @(posedge clock) begin
        model_live <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                mslot[d] = 0;
                for (int t = 0; t < 8; t++) begin
                    mpc[d][t]  = rpc[d];
                    mrun[d][t] = (t < cnt[d]) ? rmask[d][t] : 1'b0;
                end
                e_pc[d] = 0; e_th[d] = 0; e_v[d] = 0;
            end else begin
                ctrl_ok = ctrl_valid && (int'(ctrl_thread) < cnt[d]);
                fb_ok   = fb_valid && (int'(fb_thread) < cnt[d]) && mrun[d][fb_thread]
                          && !(ctrl_ok && ctrl_thread == fb_thread);
                if (fb_ok && fb_io_ready)
                    mpc[d][fb_thread] = fb_jump ? int'(fb_target) : (mpc[d][fb_thread] + 1) % 1024;
                if (ctrl_ok) begin
                    mrun[d][ctrl_thread] = ctrl_op;
                    if (ctrl_op) mpc[d][ctrl_thread] = int'(ctrl_pc);
                end
                r = mslot[d] % cnt[d];
                e_th[d] = r;
                e_pc[d] = mpc[d][r];
                e_v[d]  = mrun[d][r];
                mslot[d]++;
            end
            e_run[d] = 0;
            for (int t = 0; t < cnt[d]; t++) e_run[d] += int'(mrun[d][t]) << t;
        end
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clock) begin
        if (model_live) begin
            checkOutput("dut8 issue_valid",  int'(v8),   e_v[0]);
            checkOutput("dut8 issue_thread", int'(th8),  e_th[0]);
            checkOutput("dut8 issue_pc",     int'(pc8),  e_pc[0]);
            checkOutput("dut8 running",      int'(run8), e_run[0]);
            checkOutput("dut6 issue_valid",  int'(v6),   e_v[1]);
            checkOutput("dut6 issue_thread", int'(th6),  e_th[1]);
            checkOutput("dut6 issue_pc",     int'(pc6),  e_pc[1]);
            checkOutput("dut6 running",      int'(run6), e_run[1]);
        end
    end

    task automatic clearInputs();
        fb_valid = 0; fb_thread = 0; fb_io_ready = 0; fb_jump = 0; fb_target = 0;
        ctrl_valid = 0; ctrl_op = 0; ctrl_thread = 0; ctrl_pc = 0;
    endtask

    // Returns at a falling edge where the next rising edge issues thread t of
    // the 8-thread DUT, i.e. the outputs currently show thread t-1.
    task automatic waitForSlot(input int t);
        int n = 0;
        while ((mslot[0] % 8) != t && n < 20) begin
            @(negedge clock);
            n++;
        end
        if ((mslot[0] % 8) != t) begin
            n_fail++;
            $display("[TB] FAIL wait_slot: slot %0d not reached within 20 cycles", t);
        end
    endtask

    task automatic applyStimulus(input bit fv, input int ft, input bit rdy, input bit jmp,
                                 input int tgt, input bit cv, input bit op, input int ct,
                                 input int cpc);
        fb_valid = fv; fb_thread = 3'(ft); fb_io_ready = rdy; fb_jump = jmp;
        fb_target = 10'(tgt);
        ctrl_valid = cv; ctrl_op = op; ctrl_thread = 3'(ct); ctrl_pc = 10'(cpc);
        @(negedge clock);
        clearInputs();
    endtask

    int exp_pc3 [5] = '{'h10, 'h11, 'h12, 'h3FF, 'h000};

    initial begin
        reset_n = 1'b0;
        clearInputs();
        repeat (3) @(negedge clock);
        checkOutput("reset issue_valid",  int'(v8),   0);
        checkOutput("reset issue_thread", int'(th8),  0);
        checkOutput("reset issue_pc",     int'(pc8),  0);
        checkOutput("reset running8",     int'(run8), 'hFF);
        checkOutput("reset running6",     int'(run6), 'h2D);

        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            checkOutput("first lap thread8", int'(th8), i % 8);
            checkOutput("first lap pc8",     int'(pc8), 'h10);
            checkOutput("first lap valid8",  int'(v8),  1);
            checkOutput("first lap thread6", int'(th6), i % 6);
            checkOutput("first lap valid6",  int'(v6),  (i % 6 == 1 || i % 6 == 4) ? 0 : 1);
        end

        // Thread 3: sequential, sequential, jump to 0x3FF, sequential wrap
        for (int i = 0; i < 5; i++) begin
            waitForSlot(4);
            checkOutput("t3 visit pc", int'(pc8), exp_pc3[i]);
            if (i < 4) applyStimulus(1, 3, 1, (i == 2), 'h3FF, 0, 0, 0, 0);
        end

        // Thread 5: io not ready with a jump must replay
        waitForSlot(6);
        checkOutput("t5 before replay", int'(pc8), 'h10);
        applyStimulus(1, 5, 0, 1, 'h200, 0, 0, 0, 0);
        waitForSlot(6);
        checkOutput("t5 replay pc", int'(pc8), 'h10);

        // Thread 2: halt, then start alongside conflicting feedback
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 2, 0);
        checkOutput("halt running8", int'(run8), 'hFB);
        waitForSlot(3);
        checkOutput("halted t2 valid", int'(v8),  0);
        checkOutput("halted t2 pc",    int'(pc8), 'h10);
        applyStimulus(1, 2, 1, 1, 'h155, 1, 1, 2, 'h080);
        waitForSlot(3);
        checkOutput("started t2 valid", int'(v8),  1);
        checkOutput("started t2 pc",    int'(pc8), 'h080);

        // Thread 4: feedback in its own issue cycle is bypassed
        waitForSlot(4);
        applyStimulus(1, 4, 1, 1, 'h0AB, 0, 0, 0, 0);
        checkOutput("bypass t4 thread", int'(th8), 4);
        checkOutput("bypass t4 pc",     int'(pc8), 'h0AB);

        // Thread 7 halt: out of range for the 6-thread DUT
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 7, 0);
        checkOutput("t7 halt running8", int'(run8), 'h7F);
        checkOutput("t7 halt running6", int'(run6), 'h2D);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 399) != 0);
            fb_valid    = $urandom_range(0, 1);
            fb_thread   = 3'($urandom_range(0, 7));
            fb_io_ready = ($urandom_range(0, 3) != 0);
            fb_jump     = ($urandom_range(0, 3) == 0);
            fb_target   = 10'($urandom);
            ctrl_valid  = ($urandom_range(0, 9) == 0);
            ctrl_op     = $urandom_range(0, 1);
            ctrl_thread = 3'($urandom_range(0, 7));
            ctrl_pc     = 10'($urandom);
            @(negedge clock);
        end
        reset_n = 1'b1;
        clearInputs();
        repeat (5) @(negedge clock);

        // Mid-sequence reset with commands present that must be ignored
        reset_n = 1'b0;
        fb_valid = 1; fb_thread = 0; fb_io_ready = 1; fb_jump = 1; fb_target = 'h3AA;
        ctrl_valid = 1; ctrl_op = 1; ctrl_thread = 1; ctrl_pc = 'h2BB;
        @(negedge clock);
        checkOutput("midreset valid8",   int'(v8),   0);
        checkOutput("midreset thread8",  int'(th8),  0);
        checkOutput("midreset pc8",      int'(pc8),  0);
        checkOutput("midreset running8", int'(run8), 'hFF);
        checkOutput("midreset running6", int'(run6), 'h2D);
        reset_n = 1'b1;
        clearInputs();
        @(negedge clock);
        checkOutput("post reset pc8", int'(pc8), 'h10);
        checkOutput("post reset pc6", int'(pc6), 'h20);
        @(negedge clock);
        checkOutput("post reset t1 pc8", int'(pc8), 'h10);
        checkOutput("post reset t1 valid6", int'(v6), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
